// File: rtl/router_pkt_tx_if.sv
// Bundled request, payload and router-side bus signals of the router packet transmitter.
// The transmitter uses the master modport; benches and hosts use the slave side.
interface router_pkt_tx_if;
   logic       start;
   logic [1:0] addr;
   logic [5:0] len;
   logic       corrupt;
   logic [7:0] pl_data;
   logic       pl_valid;
   logic       pl_ready;
   logic       busy;
   logic [7:0] data_out;
   logic       pkt_valid;
   logic       tx_active;
   logic       done;
   logic       req_err;

   modport master (
      input  start, addr, len, corrupt, pl_data, pl_valid, busy,
      output pl_ready, data_out, pkt_valid, tx_active, done, req_err
   );

   modport slave (
      output start, addr, len, corrupt, pl_data, pl_valid, busy,
      input  pl_ready, data_out, pkt_valid, tx_active, done, req_err
   );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router: stages a payload, then streams header, payload and
// XOR parity gap-free while honouring router busy; parity can be deliberately corrupted.
module router_pkt_tx #(
   parameter int         MAX_LEN      = 63,
   parameter logic [1:0] ADDR_MAX     = 2'd2,
   parameter logic [7:0] CORRUPT_MASK = 8'h01
) (
   input  logic            clock,
   input  logic            reset,
   router_pkt_tx_if.master bus
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] LOAD    = 3'd1;
   localparam logic [2:0] HEADER  = 3'd2;
   localparam logic [2:0] PAYLOAD = 3'd3;
   localparam logic [2:0] PARITY  = 3'd4;

   localparam logic [5:0] LEN_LIMIT = 6'(MAX_LEN);

   logic [2:0] state;
   logic [1:0] addr_q;
   logic [5:0] len_q;
   logic       corrupt_q;
   logic [5:0] wr_cnt;
   logic [5:0] rd_cnt;
   logic [7:0] parity_acc;
   logic [7:0] data_q;
   logic       pkt_valid_q;
   logic       done_q;
   logic       req_err_q;

   logic [7:0] pkt_buf [MAX_LEN];

   logic       start_ok;
   logic       load_last;
   logic [7:0] corrupt_byte;

   assign start_ok     = bus.start && (bus.addr <= ADDR_MAX) && (bus.len != 6'd0) &&
                         (bus.len <= LEN_LIMIT);
   assign load_last    = bus.pl_valid && (wr_cnt == (len_q - 6'd1));
   assign corrupt_byte = corrupt_q ? CORRUPT_MASK : 8'h00;

   assign bus.pl_ready  = (state == LOAD);
   assign bus.tx_active = (state != IDLE);
   assign bus.data_out  = data_q;
   assign bus.pkt_valid = pkt_valid_q;
   assign bus.done      = done_q;
   assign bus.req_err   = req_err_q;

   // Staging buffer has no reset; each packet overwrites slots 0..len-1 before they are read.
   always_ff @(posedge clock) begin
      if ((state == LOAD) && bus.pl_valid) begin
         pkt_buf[wr_cnt] <= bus.pl_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         addr_q      <= 2'd0;
         len_q       <= 6'd0;
         corrupt_q   <= 1'b0;
         wr_cnt      <= 6'd0;
         rd_cnt      <= 6'd0;
         parity_acc  <= 8'h00;
         data_q      <= 8'h00;
         pkt_valid_q <= 1'b0;
         done_q      <= 1'b0;
         req_err_q   <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         req_err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  addr_q    <= bus.addr;
                  len_q     <= bus.len;
                  corrupt_q <= bus.corrupt;
                  wr_cnt    <= 6'd0;
                  state     <= LOAD;
               end else if (bus.start) begin
                  req_err_q <= 1'b1;
               end
            end
            LOAD: begin
               if (load_last) begin
                  data_q      <= {len_q, addr_q};
                  parity_acc  <= {len_q, addr_q};
                  pkt_valid_q <= 1'b1;
                  state       <= HEADER;
               end else if (bus.pl_valid) begin
                  wr_cnt <= wr_cnt + 6'd1;
               end
            end
            HEADER: begin
               if (!bus.busy) begin
                  data_q <= pkt_buf[0];
                  rd_cnt <= 6'd1;
                  state  <= PAYLOAD;
               end
            end
            // rd_cnt is compared before it increments, so len=63 never needs a seventh bit.
            PAYLOAD: begin
               if (!bus.busy) begin
                  parity_acc <= parity_acc ^ data_q;
                  if (rd_cnt < len_q) begin
                     data_q <= pkt_buf[rd_cnt];
                     rd_cnt <= rd_cnt + 6'd1;
                  end else begin
                     data_q      <= parity_acc ^ data_q ^ corrupt_byte;
                     pkt_valid_q <= 1'b0;
                     state       <= PARITY;
                  end
               end
            end
            PARITY: begin
               if (!bus.busy) begin
                  data_q <= 8'h00;
                  done_q <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: begin
               data_q      <= 8'h00;
               pkt_valid_q <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: directed packets push expected beats, a negedge
// monitor compares every presented beat (held or consumed) and the done pulse.
module tb_router_pkt_tx;

   typedef struct {
      logic [7:0] data;
      logic       valid;
   } beat_t;

   logic clock;
   logic reset;

   router_pkt_tx_if bus ();

   router_pkt_tx dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   int         checks;
   int         errors;
   beat_t      exp_q[$];
   logic       expect_done;
   int         held_cycles;
   logic [7:0] busy_target;
   int         busy_left;
   logic [7:0] payload [64];

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Router model: stall once the chosen byte is on the bus, for busy_left cycles.
   initial begin
      bus.busy = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         if (busy_left > 0 && bus.pkt_valid && bus.data_out == busy_target) begin
            bus.busy = 1'b1;
            busy_left--;
         end else begin
            bus.busy = 1'b0;
         end
      end
   end

   always @(negedge clock) begin
      if (!reset) begin
         if (expect_done) begin
            checkOutput("done_pulse", 16'({bus.done, bus.tx_active}), 16'h0002);
            expect_done = 1'b0;
         end else if (bus.done) begin
            checkOutput("unexpected_done", 16'(bus.done), 16'h0000);
         end
         if (bus.tx_active && !bus.pl_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_beat", 16'({bus.pkt_valid, bus.data_out}), 16'hFFFF);
            end else if (bus.busy) begin
               held_cycles++;
               checkOutput("held_beat", 16'({bus.pkt_valid, bus.data_out}),
                           16'({exp_q[0].valid, exp_q[0].data}));
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               checkOutput("beat", 16'({bus.pkt_valid, bus.data_out}), 16'({e.valid, e.data}));
               if (!e.valid) expect_done = 1'b1;
            end
         end
      end
   end

   // Issues start, queues the expected beats and feeds payload[0..l-1] with gap idle cycles.
   task automatic applyStimulus(input logic [1:0] a, input logic [5:0] l, input logic c,
                                input int gap, input logic [7:0] exp_hdr,
                                input logic [7:0] exp_par);
      exp_q.push_back('{exp_hdr, 1'b1});
      for (int i = 0; i < int'(l); i++) exp_q.push_back('{payload[i], 1'b1});
      exp_q.push_back('{exp_par, 1'b0});
      bus.start   = 1'b1;
      bus.addr    = a;
      bus.len     = l;
      bus.corrupt = c;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      checkOutput("load_pl_ready", 16'(bus.pl_ready), 16'h0001);
      for (int i = 0; i < int'(l); i++) begin
         bus.pl_data  = payload[i];
         bus.pl_valid = 1'b1;
         @(posedge clock);
         #1;
         bus.pl_valid = 1'b0;
         if (i < int'(l) - 1) begin
            for (int g = 0; g < gap; g++) begin
               checkOutput("gap_wait", 16'({bus.pl_ready, bus.pkt_valid}), 16'h0002);
               @(posedge clock);
               #1;
            end
         end
      end
      checkOutput("header_after_load", 16'({bus.pl_ready, bus.pkt_valid}), 16'h0001);
   endtask

   task automatic waitDone(input logic stray);
      int   n;
      logic saw_err;
      n       = 0;
      saw_err = 1'b0;
      while (!bus.done && n < 300) begin
         bus.start = (stray && n == 3);
         bus.addr  = 2'd3;
         bus.len   = 6'd0;
         @(posedge clock);
         #1;
         if (bus.req_err) saw_err = 1'b1;
         n++;
      end
      bus.start = 1'b0;
      if (n >= 300) checkOutput("done_timeout", 16'h0000, 16'h0001);
      if (stray) checkOutput("stray_start_ignored", 16'(saw_err), 16'h0000);
      checkOutput("queue_drained", 16'(exp_q.size()), 16'h0000);
   endtask

   task automatic illegalStart(input logic [1:0] a, input logic [5:0] l);
      bus.start = 1'b1;
      bus.addr  = a;
      bus.len   = l;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      checkOutput("req_err_pulse", 16'({bus.req_err, bus.tx_active}), 16'h0002);
      @(posedge clock);
      #1;
      checkOutput("req_err_cleared", 16'({bus.req_err, bus.tx_active}), 16'h0000);
   endtask

   initial begin
      int n;
      checks       = 0;
      errors       = 0;
      expect_done  = 1'b0;
      held_cycles  = 0;
      busy_left    = 0;
      busy_target  = 8'h00;
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.addr     = 2'd0;
      bus.len      = 6'd0;
      bus.corrupt  = 1'b0;
      bus.pl_data  = 8'h00;
      bus.pl_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset_data_out", 16'(bus.data_out), 16'h0000);
      checkOutput("reset_flags", 16'({bus.pkt_valid, bus.pl_ready, bus.tx_active,
                                      bus.done, bus.req_err}), 16'h0000);
      reset = 1'b0;
      @(posedge clock);
      #1;

      for (int i = 0; i < 5; i++) payload[i] = 8'h11 + 8'(i);
      $display("[TB] len=5 addr=2 clean packet, then corrupt packet back-to-back");
      applyStimulus(2'd2, 6'd5, 1'b0, 0, 8'h16, 8'h07);
      waitDone(1'b0);
      applyStimulus(2'd2, 6'd5, 1'b1, 0, 8'h16, 8'h06);
      waitDone(1'b0);

      $display("[TB] busy stall on payload 12");
      held_cycles = 0;
      busy_target = 8'h12;
      busy_left   = 3;
      applyStimulus(2'd2, 6'd5, 1'b0, 0, 8'h16, 8'h07);
      waitDone(1'b0);
      checkOutput("busy_held_cycles", 16'(held_cycles), 16'd3);

      $display("[TB] pl_valid gaps during load");
      applyStimulus(2'd2, 6'd5, 1'b0, 2, 8'h16, 8'h07);
      waitDone(1'b0);

      $display("[TB] illegal starts and stray start mid-packet");
      illegalStart(2'd3, 6'd5);
      illegalStart(2'd2, 6'd0);
      applyStimulus(2'd1, 6'd5, 1'b0, 0, 8'h15, 8'h04);
      waitDone(1'b1);

      $display("[TB] reset mid-payload, then len=63 addr=0");
      applyStimulus(2'd2, 6'd5, 1'b0, 0, 8'h16, 8'h07);
      n = 0;
      while (!(bus.pkt_valid && bus.data_out == 8'h13) && n < 50) begin
         @(posedge clock);
         #1;
         n++;
      end
      if (n >= 50) checkOutput("payload_wait_timeout", 16'h0000, 16'h0001);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midreset_data_out", 16'(bus.data_out), 16'h0000);
      checkOutput("midreset_flags", 16'({bus.pkt_valid, bus.tx_active, bus.pl_ready}), 16'h0000);
      exp_q.delete();
      expect_done = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
      for (int i = 0; i < 63; i++) payload[i] = 8'(i + 1);
      applyStimulus(2'd0, 6'd63, 1'b0, 0, 8'hFC, 8'hFC);
      waitDone(1'b0);

      repeat (3) @(posedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not complete");
      $fatal(1, "[TB] global timeout");
   end

endmodule
